ram_read_ctrl: RTL and testbench

RAM_READ_CTRL -- requirements
Module: ram_read_ctrl

---
 rtl/ram_read_ctrl_pkg.sv | 21 ++
 rtl/ram_read_ctrl_if.sv | 32 +++
 rtl/ram_read_ctrl.sv | 121 ++++++++++++
 tb/tb_ram_read_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_read_ctrl_pkg.sv
// Shared definitions for the RAM read/write controllers: FSM state encoding,
// default bus widths and the latency-counter width helper.
package ram_ctrl_pkg;

  localparam int DEF_SIZE_DATA  = 8;
  localparam int DEF_SIZE_ADDR  = 4;
  localparam int MAX_RD_LATENCY = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  // Width needed to hold the values 0..lat in the latency counter.
  function automatic int lat_cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/ram_read_ctrl_if.sv
// Bundles the requester-side and RAM-side signals of one read controller.
interface ram_read_ctrl_if #(
  parameter int SIZE_DATA = ram_ctrl_pkg::DEF_SIZE_DATA,
  parameter int SIZE_ADDR = ram_ctrl_pkg::DEF_SIZE_ADDR
) ();

  logic                 rd_en_req;
  logic [SIZE_ADDR-1:0] addr_req;
  logic                 ram_rd_en;
  logic [SIZE_ADDR-1:0] ram_addr;
  logic [SIZE_DATA-1:0] ram_data;
  logic [SIZE_DATA-1:0] data_rd;
  logic                 done;
  logic                 busy;
  logic                 overrun;

  modport master (
    output rd_en_req, addr_req,
    input  data_rd, done, busy, overrun
  );

  modport slave (
    input  rd_en_req, addr_req, ram_data,
    output ram_rd_en, ram_addr, data_rd, done, busy, overrun
  );

  modport ram (
    input  ram_rd_en, ram_addr,
    output ram_data
  );

endinterface

// File: rtl/ram_read_ctrl.sv
// Read controller for a single-port RAM with a fixed read latency: latches a
// request, strobes the RAM once, waits RD_LATENCY cycles and captures the data.
module ram_read_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int SIZE_DATA  = DEF_SIZE_DATA,
  parameter int SIZE_ADDR  = DEF_SIZE_ADDR,
  parameter int RD_LATENCY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rd_en,
  input  logic [SIZE_ADDR-1:0] i_addr,
  output logic                 o_rd_en,
  output logic [SIZE_ADDR-1:0] o_addr,
  input  logic [SIZE_DATA-1:0] i_data_rd,
  output logic [SIZE_DATA-1:0] o_data_rd,
  output logic                 o_done,
  output logic                 o_busy,
  output logic                 o_overrun
);

  localparam int CNT_W = lat_cnt_w(RD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  rd_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SIZE_ADDR-1:0] addr_q, addr_d;
  logic [SIZE_DATA-1:0] data_q, data_d;
  logic                 rd_en_q, rd_en_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;

  // Next-state, counter, capture and output decode for the read sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    overrun_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_rd_en) begin
          addr_d  = i_addr;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d     = CNT_LOAD;
        state_d   = ST_WAIT;
        overrun_d = i_rd_en;
      end
      ST_WAIT: begin
        overrun_d = i_rd_en;
        // The <= guard keeps the counter from ever wrapping below zero.
        if (cnt_q <= CNT_ONE) begin
          data_d  = i_data_rd;
          cnt_d   = CNT_ZERO;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        // DONE is also the acceptance slot, so a held request repeats every
        // RD_LATENCY+2 cycles instead of losing a cycle in IDLE.
        if (i_rd_en) begin
          addr_d  = i_addr;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    rd_en_d = (state_d == ST_ISSUE);
    done_d  = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, counter, address/data holding registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      addr_q    <= {SIZE_ADDR{1'b0}};
      data_q    <= {SIZE_DATA{1'b0}};
      rd_en_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_en_q   <= rd_en_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_rd_en   = rd_en_q;
  assign o_addr    = addr_q;
  assign o_data_rd = data_q;
  assign o_done    = done_q;
  assign o_busy    = busy_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_ram_read_ctrl.sv
// Scoreboard bench: two controllers (latency 1 and 3) each driving a RAM model;
// expected strobes and completions are queued at stimulus time and checked by a monitor.
module tb_ram_read_ctrl;
  import ram_ctrl_pkg::*;

  localparam int DW = DEF_SIZE_DATA;
  localparam int AW = DEF_SIZE_ADDR;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_read_ctrl_if #(.SIZE_DATA(DW), .SIZE_ADDR(AW)) if1 ();
  ram_read_ctrl_if #(.SIZE_DATA(DW), .SIZE_ADDR(AW)) if3 ();

  ram_read_ctrl #(.SIZE_DATA(DW), .SIZE_ADDR(AW), .RD_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(if1.rd_en_req), .i_addr(if1.addr_req),
    .o_rd_en(if1.ram_rd_en), .o_addr(if1.ram_addr), .i_data_rd(if1.ram_data),
    .o_data_rd(if1.data_rd), .o_done(if1.done), .o_busy(if1.busy), .o_overrun(if1.overrun)
  );

  ram_read_ctrl #(.SIZE_DATA(DW), .SIZE_ADDR(AW), .RD_LATENCY(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(if3.rd_en_req), .i_addr(if3.addr_req),
    .o_rd_en(if3.ram_rd_en), .o_addr(if3.ram_addr), .i_data_rd(if3.ram_data),
    .o_data_rd(if3.data_rd), .o_done(if3.done), .o_busy(if3.busy), .o_overrun(if3.overrun)
  );

  // RAM preload contents.
  function automatic logic [DW-1:0] preload(input logic [AW-1:0] a);
    case (a)
      4'd2:    return 8'h11;
      4'd3:    return 8'hA5;
      4'd7:    return 8'h3C;
      4'd9:    return 8'hEE;
      default: return {a, ~a};
    endcase
  endfunction

  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe3 [3];

  always @(posedge clk) begin
    if (if1.ram_rd_en) pipe1 <= preload(if1.ram_addr);
  end

  always @(posedge clk) begin
    if (if3.ram_rd_en) pipe3[0] <= preload(if3.ram_addr);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign if1.ram_data = pipe1;
  assign if3.ram_data = pipe3[2];

  exp_t          exp_q  [2][$];
  logic [AW-1:0] addr_q [2][$];
  logic [DW-1:0] model_data [2];
  logic [AW-1:0] model_addr [2];
  logic          prev_rd [2];
  int            ovr_cnt [2];
  int            cyc     = 0;
  logic          rst_smp = 1'b0;
  int            total   = 0;
  int            passed  = 0;
  int            ovr_base;
  int            k;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s (dut L=%0d) at cycle %0d: actual 0x%0h required 0x%0h",
                  name, (d == 0) ? 1 : 3, cyc, act, expv);
  endtask

  task automatic mon(input int d, input logic rd, input logic dn, input logic bsy, input logic ovr,
                     input logic [AW-1:0] ad, input logic [DW-1:0] dt);
    exp_t e;
    if (!rst_smp) begin
      chk("reset_ctrl", d, {28'd0, rd, dn, bsy, ovr}, 32'd0);
      chk("reset_addr", d, 32'(ad), 32'd0);
      chk("reset_data", d, 32'(dt), 32'd0);
      model_data[d] = '0;
      model_addr[d] = '0;
      prev_rd[d]    = 1'b0;
    end else begin
      if (rd) begin
        chk("rd_en_single_cycle", d, 32'(prev_rd[d]), 32'd0);
        chk("rd_en_expected", d, 32'(addr_q[d].size() != 0), 32'd1);
        if (addr_q[d].size() != 0) model_addr[d] = addr_q[d].pop_front();
      end
      chk("addr_hold", d, 32'(ad), 32'(model_addr[d]));
      if (dn) begin
        chk("done_expected", d, 32'(exp_q[d].size() != 0), 32'd1);
        if (exp_q[d].size() != 0) begin
          e = exp_q[d].pop_front();
          chk("done_cycle", d, 32'(cyc), 32'(e.cyc));
          model_data[d] = e.data;
        end
        chk("busy_in_done", d, 32'(bsy), 32'd1);
      end
      chk("data_hold", d, 32'(dt), 32'(model_data[d]));
      if (ovr) ovr_cnt[d]++;
      prev_rd[d] = rd;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc     = cyc + 1;
      rst_smp = rst_n;
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      mon(0, if1.ram_rd_en, if1.done, if1.busy, if1.overrun, if1.ram_addr, if1.data_rd);
      mon(1, if3.ram_rd_en, if3.done, if3.busy, if3.overrun, if3.ram_addr, if3.data_rd);
    end
  end

  task automatic drive(input int d, input logic en, input logic [AW-1:0] a);
    if (d == 0) begin
      if1.rd_en_req = en;
      if1.addr_req  = a;
    end else begin
      if3.rd_en_req = en;
      if3.addr_req  = a;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle request issued just after a falling edge; sampled by the next rising edge.
  task automatic req(input int d, input logic [AW-1:0] a);
    int   lat = (d == 0) ? 1 : 3;
    exp_t e;
    e.data = preload(a);
    e.cyc  = cyc + lat + 2;
    exp_q[d].push_back(e);
    addr_q[d].push_back(a);
    drive(d, 1'b1, a);
    @(negedge clk);
    drive(d, 1'b0, a);
  endtask

  initial begin
    ovr_cnt[0] = 0;
    ovr_cnt[1] = 0;
    drive(0, 1'b0, 4'd0);
    drive(1, 1'b0, 4'd0);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Single read of address 3.
    req(0, 4'd3);
    idle(4);

    // Sweep all addresses at minimum spacing.
    ovr_base = ovr_cnt[0];
    for (int a = 0; a < 16; a++) begin
      req(0, 4'(a));
      idle(2);
    end
    idle(3);
    chk("seq_no_overrun", 0, 32'(ovr_cnt[0] - ovr_base), 32'd0);

    // Level-held request for 10 edges: accepts on edges 0, 3, 6, 9.
    ovr_base = ovr_cnt[0];
    k = cyc;
    for (int i = 0; i < 10; i += 3) begin
      exp_q[0].push_back('{data: preload(4'd5), cyc: k + 1 + i + 2});
      addr_q[0].push_back(4'd5);
    end
    drive(0, 1'b1, 4'd5);
    idle(10);
    drive(0, 1'b0, 4'd5);
    idle(5);
    chk("held_overruns", 0, 32'(ovr_cnt[0] - ovr_base), 32'd6);

    // Data holds 0x11 until the second read captures 0xEE.
    req(0, 4'd2);
    idle(2);
    req(0, 4'd9);
    idle(4);

    // Latency-3 controller: single read then back-to-back reads.
    ovr_base = ovr_cnt[1];
    req(1, 4'd7);
    idle(6);
    req(1, 4'd3);
    idle(4);
    req(1, 4'd2);
    idle(7);
    chk("l3_no_overrun", 1, 32'(ovr_cnt[1] - ovr_base), 32'd0);

    // Reset while the latency-1 controller is in WAIT.
    req(0, 4'd3);
    idle(1);
    exp_q[0].delete();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    req(0, 4'd3);
    idle(4);

    chk("l1_queues_drained", 0, 32'(exp_q[0].size() + addr_q[0].size()), 32'd0);
    chk("l3_queues_drained", 1, 32'(exp_q[1].size() + addr_q[1].size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
